// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with write bypass,
// two prioritised write ports and a per-register pending scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
  logic              wr0_ok, wr1_ok, iss_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr0_ok = wr0_en && !is_zero(wr0_addr);
  assign wr1_ok = wr1_en && !is_zero(wr1_addr);
  assign iss_ok = iss_en && !is_zero(iss_addr);

  // Port 1 is applied after port 0 so it wins on a shared address; the issue
  // set is applied last because a new producer supersedes the completing one.
  always_comb begin
    regs_d     = regs_q;
    pend_d     = pend_q;
    pend_cnt_d = '0;
    if (wr0_ok) begin
      regs_d[wr0_addr] = wr0_data;
      pend_d[wr0_addr] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[wr1_addr] = wr1_data;
      pend_d[wr1_addr] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[iss_addr] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;

    assign ra   = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit0 = wr0_en && (wr0_addr == ra);
    assign hit1 = wr1_en && (wr1_addr == ra);

    // The zero register is tested first so it never picks up bypassed data.
    assign rd_data[g*DATA_W +: DATA_W] = is_zero(ra) ? '0       :
                                         hit1        ? wr1_data :
                                         hit0        ? wr0_data :
                                                       regs_q[ra];
    assign rd_busy[g] = pend_q[ra] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default-parameter instance and a
// NUM_RD=4 / ADDR_W=3 / DATA_W=16 instance, checked through an expected queue.
module tb_regfile_mp;

  localparam int S_A_RD0 = 0, S_A_RD1 = 1, S_A_BUSY = 2, S_A_CNT = 3;
  localparam int S_B_RD0 = 4, S_B_BUSY = 8, S_B_CNT = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_w0e, a_w1e, a_ie;
  logic [4:0]  a_w0a, a_w1a, a_ia;
  logic [31:0] a_w0d, a_w1d;
  logic [9:0]  a_ra;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [5:0]  a_pend_cnt;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(a_w0e), .wr0_addr(a_w0a), .wr0_data(a_w0d),
    .wr1_en(a_w1e), .wr1_addr(a_w1a), .wr1_data(a_w1d),
    .iss_en(a_ie), .iss_addr(a_ia),
    .rd_addr(a_ra), .rd_data(a_rd_data), .rd_busy(a_rd_busy), .pend_cnt(a_pend_cnt)
  );

  // Instance B: four read ports, eight 16-bit registers
  logic        b_w0e, b_w1e, b_ie;
  logic [2:0]  b_w0a, b_w1a, b_ia;
  logic [15:0] b_w0d, b_w1d;
  logic [11:0] b_ra;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic [3:0]  b_pend_cnt;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(b_w0e), .wr0_addr(b_w0a), .wr0_data(b_w0d),
    .wr1_en(b_w1e), .wr1_addr(b_w1a), .wr1_data(b_w1d),
    .iss_en(b_ie), .iss_addr(b_ia),
    .rd_addr(b_ra), .rd_data(b_rd_data), .rd_busy(b_rd_busy), .pend_cnt(b_pend_cnt)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic expect_val(input int sel, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_A_RD0:  return a_rd_data[31:0];
      S_A_RD1:  return a_rd_data[63:32];
      S_A_BUSY: return {30'b0, a_rd_busy};
      S_A_CNT:  return {26'b0, a_pend_cnt};
      4, 5, 6, 7: return {16'b0, b_rd_data[(sel-4)*16 +: 16]};
      S_B_BUSY: return {28'b0, b_rd_busy};
      S_B_CNT:  return {28'b0, b_pend_cnt};
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: outputs are combinational/registered, so sample mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, a;
      int          s;
      string       nm;
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      a  = observe(s);
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step_a(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    a_w0e = w0e; a_w0a = w0a; a_w0d = w0d;
    a_w1e = w1e; a_w1a = w1a; a_w1d = w1d;
    a_ie  = ie;  a_ia  = ia;
    a_ra  = {ra1, ra0};
  endtask

  task automatic step_b(input logic w0e, input logic [2:0] w0a, input logic [15:0] w0d,
                        input logic w1e, input logic [2:0] w1a, input logic [15:0] w1d,
                        input logic ie, input logic [2:0] ia,
                        input logic [11:0] ra);
    @(posedge clk);
    #1;
    b_w0e = w0e; b_w0a = w0a; b_w0d = w0d;
    b_w1e = w1e; b_w1a = w1a; b_w1d = w1d;
    b_ie  = ie;  b_ia  = ia;
    b_ra  = ra;
  endtask

  task automatic idle_a(input logic [4:0] ra0, input logic [4:0] ra1);
    step_a(0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  task automatic idle_b(input logic [11:0] ra);
    step_b(0, 0, 0, 0, 0, 0, 0, 0, ra);
  endtask

  initial begin
    a_w0e = 0; a_w0a = 0; a_w0d = 0; a_w1e = 0; a_w1a = 0; a_w1d = 0;
    a_ie = 0; a_ia = 0; a_ra = 0;
    b_w0e = 0; b_w0a = 0; b_w0d = 0; b_w1e = 0; b_w1a = 0; b_w1d = 0;
    b_ie = 0; b_ia = 0; b_ra = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    idle_a(5, 0);
    expect_val(S_A_RD0, 32'h0, "reset_rd");
    expect_val(S_A_BUSY, 32'h0, "reset_busy");
    expect_val(S_A_CNT, 32'h0, "reset_cnt");

    // Preload r5, make r6 pending, then reset between edges
    step_a(1, 5, 32'h1234, 0, 0, 0, 1, 6, 5, 6);
    expect_val(S_A_RD0, 32'h1234, "preload_bypass");
    expect_val(S_A_BUSY, 32'h0, "issue_not_yet_busy");
    expect_val(S_A_CNT, 32'h0, "issue_cnt_before_edge");
    idle_a(5, 6);
    expect_val(S_A_RD0, 32'h1234, "preload_stored");
    expect_val(S_A_BUSY, 32'h2, "r6_busy");
    expect_val(S_A_CNT, 32'h1, "cnt_one");
    idle_a(5, 6);
    rst_n = 1'b0;
    expect_val(S_A_RD0, 32'h0, "async_reset_rd");
    expect_val(S_A_BUSY, 32'h0, "async_reset_busy");
    expect_val(S_A_CNT, 32'h0, "async_reset_cnt");
    idle_a(5, 6);
    rst_n = 1'b1;
    expect_val(S_A_RD0, 32'h0, "after_reset_rd");

    // Dual write, same address: port 1 wins
    step_a(1, 9, 32'hAAAA_0000, 1, 9, 32'h5555_FFFF, 0, 0, 9, 9);
    expect_val(S_A_RD0, 32'h5555_FFFF, "dual_bypass_p0");
    expect_val(S_A_RD1, 32'h5555_FFFF, "dual_bypass_p1");
    idle_a(9, 0);
    expect_val(S_A_RD0, 32'h5555_FFFF, "dual_stored");
    expect_val(S_A_RD1, 32'h0, "r0_zero");

    // Zero register: writes and issue dropped
    step_a(1, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 9);
    expect_val(S_A_RD0, 32'h0, "zero_no_bypass");
    expect_val(S_A_RD1, 32'h5555_FFFF, "r9_other_port");
    expect_val(S_A_BUSY, 32'h0, "zero_busy");
    expect_val(S_A_CNT, 32'h0, "zero_cnt_now");
    idle_a(0, 0);
    expect_val(S_A_RD0, 32'h0, "zero_stored");
    expect_val(S_A_BUSY, 32'h0, "zero_not_pending");
    expect_val(S_A_CNT, 32'h0, "zero_cnt_after");

    // Scoreboard flow on r8
    step_a(0, 0, 0, 0, 0, 0, 1, 8, 8, 8);
    expect_val(S_A_BUSY, 32'h0, "r8_issue_cycle");
    idle_a(8, 8);
    expect_val(S_A_BUSY, 32'h3, "r8_busy");
    expect_val(S_A_CNT, 32'h1, "r8_cnt");
    step_a(1, 8, 32'h7, 0, 0, 0, 0, 0, 8, 8);
    expect_val(S_A_RD0, 32'h7, "r8_wb_bypass");
    expect_val(S_A_RD1, 32'h7, "r8_wb_bypass_p1");
    expect_val(S_A_BUSY, 32'h0, "r8_wb_not_busy");
    expect_val(S_A_CNT, 32'h1, "r8_wb_cnt_same_cycle");
    idle_a(8, 0);
    expect_val(S_A_RD0, 32'h7, "r8_stored");
    expect_val(S_A_BUSY, 32'h0, "r8_cleared");
    expect_val(S_A_CNT, 32'h0, "r8_cnt_zero");

    // Issue and writeback collide on r10: the set wins
    step_a(0, 0, 0, 0, 0, 0, 1, 10, 10, 10);
    expect_val(S_A_CNT, 32'h0, "r10_issue_cnt");
    step_a(0, 0, 0, 1, 10, 32'h3, 1, 10, 10, 8);
    expect_val(S_A_RD0, 32'h3, "collide_bypass");
    expect_val(S_A_BUSY, 32'h0, "collide_bypass_not_busy");
    expect_val(S_A_CNT, 32'h1, "collide_cnt_now");
    idle_a(10, 10);
    expect_val(S_A_RD0, 32'h3, "collide_stored");
    expect_val(S_A_BUSY, 32'h3, "collide_still_pending");
    expect_val(S_A_CNT, 32'h1, "collide_cnt_same");

    // Distinct addresses on the two write ports
    step_a(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 3, 4);
    expect_val(S_A_RD0, 32'h33, "split_p0");
    expect_val(S_A_RD1, 32'h44, "split_p1");
    step_a(1, 10, 32'h1010, 0, 0, 0, 0, 0, 4, 10);
    expect_val(S_A_RD0, 32'h44, "r4_stored");
    expect_val(S_A_RD1, 32'h1010, "r10_wb_bypass");
    expect_val(S_A_BUSY, 32'h0, "r10_wb_not_busy");
    expect_val(S_A_CNT, 32'h1, "r10_cnt_before");
    idle_a(10, 3);
    expect_val(S_A_RD0, 32'h1010, "r10_stored");
    expect_val(S_A_RD1, 32'h33, "r3_stored");
    expect_val(S_A_CNT, 32'h0, "r10_cnt_zero");

    // Instance B: four ports, mix of bypass and stored
    step_b(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0, 12'h0);
    expect_val(S_B_CNT, 32'h0, "b_cnt_reset");
    step_b(1, 3, 16'h0333, 1, 4, 16'h0444, 0, 0, {3'd4, 3'd2, 3'd3, 3'd1});
    expect_val(S_B_RD0 + 0, 32'h1111, "b_p0_stored");
    expect_val(S_B_RD0 + 1, 32'h0333, "b_p1_bypass0");
    expect_val(S_B_RD0 + 2, 32'h2222, "b_p2_stored");
    expect_val(S_B_RD0 + 3, 32'h0444, "b_p3_bypass1");
    step_b(1, 5, 16'h5555, 1, 5, 16'hAAAA, 0, 0, {3'd7, 3'd0, 3'd4, 3'd5});
    expect_val(S_B_RD0 + 0, 32'hAAAA, "b_dual_bypass");
    expect_val(S_B_RD0 + 1, 32'h0444, "b_r4_stored");
    expect_val(S_B_RD0 + 2, 32'h0, "b_r0_zero");
    expect_val(S_B_RD0 + 3, 32'h0, "b_r7_empty");
    idle_b({3'd3, 3'd2, 3'd1, 3'd5});
    expect_val(S_B_RD0 + 0, 32'hAAAA, "b_r5_stored");
    expect_val(S_B_RD0 + 1, 32'h1111, "b_r1_stored");
    expect_val(S_B_RD0 + 2, 32'h2222, "b_r2_stored");
    expect_val(S_B_RD0 + 3, 32'h0333, "b_r3_stored");

    // Issue every non-zero register; count saturates at 7
    for (int k = 1; k <= 7; k++) begin
      step_b(0, 0, 0, 0, 0, 0, 1, 3'(k), 12'h0);
      expect_val(S_B_CNT, 32'(k - 1), "b_cnt_ramp");
    end
    step_b(0, 0, 0, 0, 0, 0, 1, 1, 12'h0);
    expect_val(S_B_CNT, 32'h7, "b_cnt_full");
    step_b(0, 0, 0, 0, 0, 0, 1, 0, 12'h0);
    expect_val(S_B_CNT, 32'h7, "b_cnt_reissue");
    step_b(1, 2, 16'h0202, 0, 0, 0, 0, 0, {3'd5, 3'd0, 3'd2, 3'd1});
    expect_val(S_B_CNT, 32'h7, "b_cnt_r0_issue");
    expect_val(S_B_BUSY, 32'h9, "b_busy_mix");
    expect_val(S_B_RD0 + 1, 32'h0202, "b_r2_wb_bypass");
    idle_b({3'd5, 3'd0, 3'd2, 3'd1});
    expect_val(S_B_CNT, 32'h6, "b_cnt_after_wb");
    expect_val(S_B_BUSY, 32'h9, "b_busy_after_wb");
    expect_val(S_B_RD0 + 1, 32'h0202, "b_r2_stored");

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 4 && exp_q.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending checks expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the successor to the single-write, dual-read datapath register file. Provides NUM_RD combinational read ports, two synchronous write ports with defined priority, same-cycle write-to-read bypass, and a per-register pending scoreboard for the pipelined datapath. Sits between decode (read, issue) and writeback (write, clear pending).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never pending

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (priority over port 0)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- iss_en  in  1  mark destination register pending
- iss_addr  in  ADDR_W  destination register being issued
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i operand not yet available
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus a pending bit per register.
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, pend_cnt 0. Resulting outputs: rd_data 0, rd_busy 0. Reset mid-operation discards all in-flight writes and issues; the first edge after deassertion behaves as normal.
- Write: on the rising edge, each enabled port writes its data to its address.
  - Same address on both ports: wr1_data is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read: combinational, with bypass. For each port i:
  - wr1 enabled and matching address: rd_data = wr1_data.
  - Otherwise wr0 enabled and matching: rd_data = wr0_data.
  - Otherwise rd_data = the stored value.
  - Address 0 with ZERO_REG=1 always reads 0 and is never bypassed.
- Scoreboard, applied at the rising edge:
  - An enabled write clears pending at its address.
  - iss_en sets pending at iss_addr.
  - Issue and write to the same address in one cycle: the set wins, because a new producer supersedes the old one.
  - iss_addr 0 with ZERO_REG=1 is ignored.
  - Re-issuing an already pending register leaves it pending; pend_cnt is unchanged.
- rd_busy[i] = pending[rd_addr_i] AND NOT (any write port enabled to rd_addr_i this cycle). A bypassed operand is therefore not busy.
- pend_cnt: registered population count of the pending bits. It is updated on each edge by the net sets and clears, and never wraps; the maximum is 2**ADDR_W − ZERO_REG.

## Timing
- Write latency: data visible at the storage outputs one edge after the write; visible on rd_data the same cycle through the bypass.
- Issue latency: pending visible on rd_busy the cycle after iss_en.
- rd_data and rd_busy are purely combinational from rd_addr, the write ports and state. There is no read latency.
- pend_cnt is registered and reflects state after the most recent edge.
- Reset assertion affects outputs immediately and needs no clock.

## Test plan
- Reset clear: preload r5=0x1234, assert rst_n low between edges. Required: rd_data(r5)=0, pend_cnt=0 without any clock edge.
- Dual write, same address: wr0 (r9, 0xAAAA0000) and wr1 (r9, 0x5555FFFF) in one cycle. Required: the bypass read returns 0x5555FFFF in that cycle, and the stored value is 0x5555FFFF next cycle.
- Zero register: write r0=0xDEADBEEF on both ports and issue r0. Required: rd_data(r0)=0, rd_busy=0, pend_cnt unchanged.
- Scoreboard flow:
  - Issue r8: next cycle rd_busy=1 and pend_cnt=1.
  - Writeback wr0 r8=7 in a later cycle: rd_busy=0 and rd_data=7 in that cycle.
  - Following cycle: pend_cnt=0.
- Issue and write collide: r10 pending, then iss_en r10 and wr1 r10=3 in the same cycle. Required: rd_data=3 in that cycle, r10 still pending next cycle, pend_cnt unchanged.
- Parameter sweep at NUM_RD=4, ADDR_W=3, DATA_W=16:
  - All four ports read distinct registers while both write ports write two of them.
  - Required: each port returns its bypassed or stored value independently.
  - Required: after issuing all of r1..r7, pend_cnt saturates at 7.
